// File: rtl/worm_tick_scheduler_if.sv
// Request/acknowledge handshake between the tick scheduler and the shared
// worm-update datapath.
interface worm_tick_scheduler_if;
  logic       upd_req;
  logic [2:0] upd_sel;
  logic       upd_grow;
  logic       upd_ack;

  modport master (output upd_req, output upd_sel, output upd_grow, input upd_ack);
  modport slave  (input upd_req, input upd_sel, input upd_grow, output upd_ack);
endinterface

// File: rtl/worm_tick_scheduler.sv
// Game-tick sequencer sharing one worm-update datapath across NUM_WORMS worms.
// Optional handshake watchdog: define WORM_SCHED_WATCHDOG_EN.
module worm_tick_scheduler #(
  parameter int NUM_WORMS = 4,
  parameter int TICK_DIV  = 250000,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [NUM_WORMS-1:0]  worm_active_i,
  input  logic [NUM_WORMS-1:0]  food_eaten_i,
  worm_tick_scheduler_if.master upd_if,
  output logic                  busy_o,
  output logic                  round_done_o,
  output logic [7:0]            overrun_cnt_o,
  output logic                  timeout_err_o
);
  localparam int CNT_W = $clog2(TICK_DIV);

  if (NUM_WORMS < 1 || NUM_WORMS > 8) begin : g_bad_num_worms
    $error("worm_tick_scheduler: NUM_WORMS must be 1..8");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("worm_tick_scheduler: TICK_DIV must be >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("worm_tick_scheduler: TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tick;
  logic [NUM_WORMS-1:0] mask_q;
  logic [NUM_WORMS-1:0] grow_q, grow_d;
  logic [NUM_WORMS-1:0] sel_oh;
  logic                 pend_q;
  logic                 req_q;
  logic [2:0]           sel_q;
  logic                 grow_out_q;
  logic                 busy_q;
  logic                 done_q;
  logic [7:0]           ovr_q;
  logic [3:0]           first_w, next_w;
  logic                 ack_hit;

`ifdef WORM_SCHED_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_q;
  logic       terr_q;
`endif

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [3:0] pick_next(input logic [NUM_WORMS-1:0] m,
                                           input logic [3:0]           lo);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_WORMS - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(lo))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tick    = enable_i && (cnt_q == CNT_W'(TICK_DIV - 1));
  assign first_w = pick_next(worm_active_i, 4'd0);
  assign next_w  = pick_next(mask_q, {1'b0, sel_q} + 4'd1);
  assign sel_oh  = NUM_WORMS'(1) << sel_q;
  assign ack_hit = (state_q == WAIT) && upd_if.upd_ack;

  always_comb begin
    cnt_d = '0;
    if (enable_i && !tick) cnt_d = cnt_q + CNT_W'(1);
  end

  // A food pulse landing on the same cycle as the ack clear must survive.
  always_comb begin
    grow_d = grow_q;
    if (ack_hit) grow_d = grow_d & ~sel_oh;
    grow_d = grow_d | food_eaten_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      grow_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      grow_q <= grow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      pend_q     <= 1'b0;
      req_q      <= 1'b0;
      sel_q      <= 3'd0;
      grow_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 8'd0;
`ifdef WORM_SCHED_WATCHDOG_EN
      wd_q       <= 8'd0;
      terr_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (!enable_i) begin
        pend_q <= 1'b0;
      end else if (tick && (state_q != IDLE)) begin
        pend_q <= 1'b1;
        ovr_q  <= sat_inc(ovr_q);
      end

      case (state_q)
        IDLE: begin
          if (tick || pend_q) begin
            mask_q <= worm_active_i;
            pend_q <= 1'b0;
            busy_q <= 1'b1;
            if (first_w[3]) begin
              sel_q   <= first_w[2:0];
              state_q <= ISSUE;
            end else begin
              // Empty round: NEXT finds nothing and closes it two cycles on.
              state_q <= NEXT;
            end
          end
        end
        ISSUE: begin
          req_q      <= 1'b1;
          grow_out_q <= |(grow_q & sel_oh);
          state_q    <= WAIT;
`ifdef WORM_SCHED_WATCHDOG_EN
          wd_q       <= 8'd0;
`endif
        end
        WAIT: begin
          if (upd_if.upd_ack) begin
            req_q      <= 1'b0;
            grow_out_q <= 1'b0;
            state_q    <= NEXT;
          end
`ifdef WORM_SCHED_WATCHDOG_EN
          else if (wd_q == WD_LAST) begin
            req_q      <= 1'b0;
            grow_out_q <= 1'b0;
            terr_q     <= 1'b1;
            state_q    <= NEXT;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
`endif
        end
        NEXT: begin
          if (next_w[3]) begin
            sel_q   <= next_w[2:0];
            state_q <= ISSUE;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign upd_if.upd_req  = req_q;
  assign upd_if.upd_sel  = sel_q;
  assign upd_if.upd_grow = grow_out_q;
  assign busy_o          = busy_q;
  assign round_done_o    = done_q;
  assign overrun_cnt_o   = ovr_q;
`ifdef WORM_SCHED_WATCHDOG_EN
  assign timeout_err_o   = terr_q;
`else
  assign timeout_err_o   = 1'b0;
`endif

endmodule
